io_port_bank: RTL

Parametrised memory-mapped I/O block for the single-cycle computer, next generation of the fixed two-in/two-out port logic beside the data memory.
- Adds N_IN debounced switch input ports, N_OUT writable output registers, and a sticky input-change status register with read-to-clear.
- Drives a selectable DIGITS-wide seven-segment display.
- Sits on the CPU data bus in parallel with data memory, selected by addr[7].

---
 rtl/io_port_bank.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/io_port_bank.sv
// Memory-mapped I/O bank: debounced switch inputs, output registers, sticky change status, 7-seg display.
// Define IO_IRQ_EN to add a registered irq output that is high while any status bit is set.
module io_port_bank #(
    parameter int N_IN       = 2,
    parameter int N_OUT      = 2,
    parameter int FIELD_W    = 4,
    parameter int DIGITS     = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    input  logic                    we,
    input  logic                    re,
    output logic [31:0]             rdata,
    input  logic [N_IN*FIELD_W-1:0] sw,
    output logic [N_OUT*32-1:0]     out_ports,
    output logic [DIGITS*7-1:0]     hex
`ifdef IO_IRQ_EN
    ,
    output logic                    irq
`endif
);

    localparam int                CNT_W      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [4:0]        IDX_OUT0   = 5'd8;
    localparam logic [4:0]        IDX_STATUS = 5'd15;
    localparam logic [4:0]        IDX_DISP   = 5'd31;

    logic                io_sel;
    logic [4:0]          idx;
    logic                wr_en;
    logic                status_rd;
    logic                unused_addr;

    logic [FIELD_W-1:0]  sync1 [N_IN];
    logic [FIELD_W-1:0]  sync2 [N_IN];
    logic [FIELD_W-1:0]  deb   [N_IN];
    logic [CNT_W-1:0]    cnt   [N_IN];
    logic [N_IN-1:0]     accept;
    logic [N_IN-1:0]     status;

    logic [31:0]         out_regs [N_OUT];
    logic [3:0]          disp_sel;

    logic [31:0]         src;
    logic                src_valid;
    logic [DIGITS*4+31:0] src_wide;

    assign io_sel      = addr[7];
    assign idx         = addr[6:2];
    assign wr_en       = we && io_sel;
    assign status_rd   = re && io_sel && (idx == IDX_STATUS);
    assign unused_addr = ^{addr[31:8], addr[1:0]};

    // A field is accepted on the DEB_CYCLES-th consecutive cycle its synchronised value differs from deb.
    always_comb begin
        accept = '0;
        for (int k = 0; k < N_IN; k++) begin
            accept[k] = (sync2[k] != deb[k]) && (cnt[k] == CNT_LAST);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: these arrays are a handful of flops, not a RAM, so every entry is reset.
            for (int k = 0; k < N_IN; k++) begin
                sync1[k] <= '0;
                sync2[k] <= '0;
                deb[k]   <= '0;
                cnt[k]   <= '0;
            end
            status <= '0;
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                // NOTE: non-blocking so sync2 takes the old sync1 and the pair forms a real two-stage chain.
                sync1[k] <= sw[k*FIELD_W +: FIELD_W];
                sync2[k] <= sync1[k];
                if (sync2[k] == deb[k]) begin
                    cnt[k] <= '0;
                end else if (accept[k]) begin
                    deb[k] <= sync2[k];
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
            // A bit set on the same edge as the clearing load survives.
            status <= (status_rd ? '0 : status) | accept;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < N_OUT; k++) begin
                out_regs[k] <= '0;
            end
            disp_sel <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (idx == IDX_OUT0 + 5'(k)) begin
                    out_regs[k] <= wdata;
                end
            end
            if (idx == IDX_DISP) begin
                disp_sel <= wdata[3:0];
            end
        end
    end

    always_comb begin
        out_ports = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out_ports[k*32 +: 32] = out_regs[k];
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns rdata and no latch is inferred.
        rdata = '0;
        if (io_sel) begin
            for (int k = 0; k < N_IN; k++) begin
                if (idx == 5'(k)) rdata[FIELD_W-1:0] = deb[k];
            end
            for (int k = 0; k < N_OUT; k++) begin
                if (idx == IDX_OUT0 + 5'(k)) rdata = out_regs[k];
            end
            if (idx == IDX_STATUS) rdata[N_IN-1:0] = status;
            if (idx == IDX_DISP)   rdata[3:0]      = disp_sel;
        end
    end

    // Display source: inputs first, then outputs; anything past them blanks the display.
    always_comb begin
        src       = '0;
        src_valid = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (disp_sel == 4'(k)) begin
                src[FIELD_W-1:0] = deb[k];
                src_valid        = 1'b1;
            end
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (disp_sel == 4'(N_IN + k)) begin
                src       = out_regs[k];
                src_valid = 1'b1;
            end
        end
    end

    assign src_wide = {{(DIGITS*4){1'b0}}, src};

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hex <= '1;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                hex[i*7 +: 7] <= src_valid ? seg7(src_wide[i*4 +: 4]) : 7'h7F;
            end
        end
    end

`ifdef IO_IRQ_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            irq <= 1'b0;
        end else begin
            irq <= |status;
        end
    end
`endif

endmodule
